seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU; SEQ_ALU_MULDIV_EN adds iterative MUL/DIVU/REMU
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic             accept;
    logic             multi;
    logic             last;
    logic [WIDTH-1:0] res, sum, dif, out_q;
    logic             ovf, ovf_q;
    logic [SW-1:0]    shamt;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign zero      = (out_q == '0);
    assign shamt     = b[SW-1:0];
    assign sum       = a + b;
    assign dif       = a - b;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (aluctl)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3:  res = a ^ b;
            4'd4:  res = a << shamt;
            4'd5:  res = a >> shamt;
            4'd6: begin
                res = dif;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'd7:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd8:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:  res = $unsigned($signed(a) >>> shamt);
            4'd12: res = ~(a | b);
            default: res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // Working registers: hi is the MUL accumulator or the DIV partial remainder,
    // wa is the shifted multiplicand or the dividend/quotient, wb the multiplier or divisor.
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi, wa, wb, hi_n, wa_n, wb_n, fin;
    logic [WIDTH:0]   sh, trial;
    logic [SW-1:0]    cnt;

    assign multi = (aluctl == 4'd10) || (aluctl == 4'd11) || (aluctl == 4'd13);
    assign last  = (state == BUSY) && (cnt == SW'(WIDTH - 1));
    assign sh    = {hi, wa[WIDTH-1]};
    assign trial = sh - {1'b0, wb};

    always_comb begin
        hi_n = hi;
        wa_n = wa;
        wb_n = wb;
        fin  = '0;
        if (op_q == 4'd10) begin
            hi_n = hi + (wb[0] ? wa : '0);
            wa_n = wa << 1;
            wb_n = wb >> 1;
            fin  = hi_n;
        end else begin
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                wa_n = {wa[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = sh[WIDTH-1:0];
                wa_n = {wa[WIDTH-2:0], 1'b0};
            end
            fin = (op_q == 4'd11) ? wa_n : hi_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            op_q  <= '0;
            hi    <= '0;
            wa    <= '0;
            wb    <= '0;
            cnt   <= '0;
        end else if (accept && multi) begin
            op_q  <= aluctl;
            hi    <= '0;
            wa    <= a;
            wb    <= b;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            out_q <= res;
            ovf_q <= ovf;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            wa  <= wa_n;
            wb  <= wb_n;
            cnt <= cnt + 1'b1;
            if (last) out_q <= fin;
        end
    end
`else
    assign multi = 1'b0;
    assign last  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            out_q <= res;
            ovf_q <= ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = multi ? BUSY : DONE;
            BUSY:    if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule
